// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite compositor.
//   KEY_COLOR_DEF  : default transparent colour key (RGB888)
//   BG_*           : background gradient constants
//   rgb_t          : packed RGB888 pixel
//   box_hit()      : signed half-open interval test used by the box check
package sprite_pkg;

    localparam logic [23:0] KEY_COLOR_DEF = 24'h800080;

    localparam logic [7:0] BG_R = 8'h3F;
    localparam logic [7:0] BG_G = 8'h00;
    localparam logic [7:0] BG_B = 8'h7F;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // True when lo <= pos < lo + len; operands are signed so off-screen
    // origins compare correctly.
    function automatic logic box_hit(input int pos, input int lo, input int len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/sprite_layer_addr.sv
// Stage-0 box test and ROM address generation for one sprite layer.
// Ports:
//   Clk, Reset        : pixel clock, synchronous active-high reset
//   DrawX, DrawY      : current draw coordinate
//   en                : layer enable
//   spr_x, spr_y      : sprite centre
//   spr_w, spr_h      : sprite size
//   in_box            : registered "pixel inside sprite" flag
//   rd_addr           : registered ROM address (0 when outside)
module sprite_layer_addr
    import sprite_pkg::*;
#(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               en,
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic [COORD_W-1:0] spr_w,
    input  logic [COORD_W-1:0] spr_h,
    output logic               in_box,
    output logic [ADDR_W-1:0]  rd_addr
);

    localparam int unsigned LinW = 2 * COORD_W + 4;

    // Two extra bits: one for sign, one for headroom on left + width.
    logic signed [COORD_W+1:0] left, top, px, py;
    logic        [COORD_W+1:0] dx, dy;
    logic        [LinW-1:0]    lin;
    logic                      in_box_d;
    logic        [ADDR_W-1:0]  rd_addr_d;

    assign left = $signed({2'b00, spr_x}) - $signed({3'b000, spr_w[COORD_W-1:1]});
    assign top  = $signed({2'b00, spr_y}) - $signed({3'b000, spr_h[COORD_W-1:1]});
    assign px   = $signed({2'b00, DrawX});
    assign py   = $signed({2'b00, DrawY});
    assign dx   = px - left;
    assign dy   = py - top;
    assign lin  = LinW'(dy) * LinW'(spr_w) + LinW'(dx);

    always_comb begin
        in_box_d  = en && box_hit(int'(px), int'(left), int'(spr_w))
                       && box_hit(int'(py), int'(top), int'(spr_h));
        rd_addr_d = in_box_d ? ADDR_W'(lin) : '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            in_box  <= 1'b0;
            rd_addr <= '0;
        end else begin
            in_box  <= in_box_d;
            rd_addr <= rd_addr_d;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// N-layer sprite mixer: per-layer ROM addressing, alignment of returned
// palette colours, priority compositing with a transparency key over a
// gradient background, and per-frame pairwise collision capture.
// Ports:
//   Clk, Reset           : pixel clock, synchronous active-high reset
//   DrawX, DrawY         : current draw coordinate
//   frame_start          : one-cycle pulse at start of frame
//   layer_en             : per-layer enable
//   spr_x/y/w/h          : packed per-layer sprite centre and size
//   rd_addr              : packed per-layer ROM address
//   rd_rgb               : packed per-layer palette colour, MEM_LAT after rd_addr
//   VGA_R, VGA_G, VGA_B  : composited pixel, MEM_LAT+2 cycles after DrawX/DrawY
//   collision            : previous frame's collision matrix, bit [i*N+j], i<j
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned          NUM_LAYERS = 4,
    parameter int unsigned          COORD_W    = 10,
    parameter int unsigned          ADDR_W     = 12,
    parameter int unsigned          COLOR_W    = 24,
    parameter int unsigned          MEM_LAT    = 1,
    parameter logic [COLOR_W-1:0]   KEY_COLOR  = KEY_COLOR_DEF
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic [COORD_W-1:0]               DrawX,
    input  logic [COORD_W-1:0]               DrawY,
    input  logic                             frame_start,
    input  logic [NUM_LAYERS-1:0]            layer_en,
    input  logic [NUM_LAYERS*COORD_W-1:0]    spr_x,
    input  logic [NUM_LAYERS*COORD_W-1:0]    spr_y,
    input  logic [NUM_LAYERS*COORD_W-1:0]    spr_w,
    input  logic [NUM_LAYERS*COORD_W-1:0]    spr_h,
    output logic [NUM_LAYERS*ADDR_W-1:0]     rd_addr,
    input  logic [NUM_LAYERS*COLOR_W-1:0]    rd_rgb,
    output logic [7:0]                       VGA_R,
    output logic [7:0]                       VGA_G,
    output logic [7:0]                       VGA_B,
    output logic [NUM_LAYERS*NUM_LAYERS-1:0] collision
);

    localparam int unsigned NN = NUM_LAYERS * NUM_LAYERS;

    logic [NUM_LAYERS-1:0] box_s0;
    logic [COORD_W-1:0]    x_s0_q;

    // Stage 0: one address/box unit per layer.
    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        sprite_layer_addr #(
            .COORD_W (COORD_W),
            .ADDR_W  (ADDR_W)
        ) u_addr (
            .Clk     (Clk),
            .Reset   (Reset),
            .DrawX   (DrawX),
            .DrawY   (DrawY),
            .en      (layer_en[g]),
            .spr_x   (spr_x[g*COORD_W +: COORD_W]),
            .spr_y   (spr_y[g*COORD_W +: COORD_W]),
            .spr_w   (spr_w[g*COORD_W +: COORD_W]),
            .spr_h   (spr_h[g*COORD_W +: COORD_W]),
            .in_box  (box_s0[g]),
            .rd_addr (rd_addr[g*ADDR_W +: ADDR_W])
        );
    end

    // Delay line: MEM_LAT further stages so box/X line up with rd_rgb.
    logic [NUM_LAYERS-1:0] box_dly_q [MEM_LAT];
    logic [COORD_W-1:0]    x_dly_q   [MEM_LAT];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_s0_q <= '0;
            for (int k = 0; k < int'(MEM_LAT); k++) begin
                box_dly_q[k] <= '0;
                x_dly_q[k]   <= '0;
            end
        end else begin
            x_s0_q       <= DrawX;
            box_dly_q[0] <= box_s0;
            x_dly_q[0]   <= x_s0_q;
            for (int k = 1; k < int'(MEM_LAT); k++) begin
                box_dly_q[k] <= box_dly_q[k-1];
                x_dly_q[k]   <= x_dly_q[k-1];
            end
        end
    end

    logic [NUM_LAYERS-1:0] box_al;
    logic [COORD_W-1:0]    x_al;

    assign box_al = box_dly_q[MEM_LAT-1];
    assign x_al   = x_dly_q[MEM_LAT-1];

    // Composite stage.
    logic [NUM_LAYERS-1:0] opaque;
    rgb_t                  pix_d, pix_q;
    logic [NN-1:0]         hit, acc_d, acc_q, coll_d, coll_q;

    always_comb begin
        opaque = '0;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            opaque[i] = box_al[i] && (rd_rgb[i*COLOR_W +: COLOR_W] != KEY_COLOR);
        end

        pix_d.r = BG_R;
        pix_d.g = BG_G;
        pix_d.b = BG_B - 8'(x_al >> 3);
        // Walk from lowest priority up so the lowest opaque index wins.
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                pix_d = rgb_t'(rd_rgb[i*COLOR_W +: COLOR_W]);
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            for (int j = i + 1; j < int'(NUM_LAYERS); j++) begin
                hit[i*NUM_LAYERS+j] = opaque[i] && opaque[j];
            end
        end

        // A hit in the frame_start cycle belongs to the frame being closed.
        if (frame_start) begin
            coll_d = acc_q | hit;
            acc_d  = '0;
        end else begin
            coll_d = coll_q;
            acc_d  = acc_q | hit;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_q  <= '0;
            acc_q  <= '0;
            coll_q <= '0;
        end else begin
            pix_q  <= pix_d;
            acc_q  <= acc_d;
            coll_q <= coll_d;
        end
    end

    assign VGA_R     = pix_q.r;
    assign VGA_G     = pix_q.g;
    assign VGA_B     = pix_q.b;
    assign collision = coll_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor (default parameters, MEM_LAT=1).
// Stimulus pushes expected pixel/address/collision values tagged with the
// cycle they must appear in; a monitor on the falling edge pops and compares.
module tb_sprite_compositor;

    localparam int N   = 4;
    localparam int CW  = 10;
    localparam int AW  = 12;
    localparam int COL = 24;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [CW-1:0]     DrawX, DrawY;
    logic              frame_start;
    logic [N-1:0]      layer_en;
    logic [N*CW-1:0]   spr_x, spr_y, spr_w, spr_h;
    logic [N*AW-1:0]   rd_addr;
    logic [N*COL-1:0]  rd_rgb;
    logic [7:0]        VGA_R, VGA_G, VGA_B;
    logic [N*N-1:0]    collision;

    sprite_compositor dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_start (frame_start),
        .layer_en    (layer_en),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_w       (spr_w),
        .spr_h       (spr_h),
        .rd_addr     (rd_addr),
        .rd_rgb      (rd_rgb),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .collision   (collision)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Palette model: the colour of each layer travels with the pixel
    // request, returning one cycle after rd_addr (MEM_LAT = 1).
    logic [N*COL-1:0] color_tb, c1, c2;
    always @(posedge Clk) begin
        c1 <= color_tb;
        c2 <= c1;
    end
    assign rd_rgb = c2;

    typedef struct {
        int          cyc;
        int          layer;
        logic [23:0] val;
    } exp_t;

    exp_t pix_q[$];
    exp_t addr_q[$];
    exp_t col_q[$];
    int checks   = 0;
    int failures = 0;

    always @(negedge Clk) begin
        exp_t e;
        logic [AW-1:0] a;
        while (pix_q.size() > 0 && pix_q[0].cyc <= cyc) begin
            e = pix_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL pix_missed cyc=%0d due=%0d", cyc, e.cyc);
            end else if ({VGA_R, VGA_G, VGA_B} !== e.val) begin
                failures++;
                $display("FAIL pix cyc=%0d got=%06h exp=%06h", cyc, {VGA_R, VGA_G, VGA_B},
                         e.val);
            end
        end
        while (addr_q.size() > 0 && addr_q[0].cyc <= cyc) begin
            e = addr_q.pop_front();
            a = rd_addr[e.layer*AW +: AW];
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL addr_missed cyc=%0d due=%0d", cyc, e.cyc);
            end else if (a !== e.val[AW-1:0]) begin
                failures++;
                $display("FAIL rd_addr%0d cyc=%0d got=%0d exp=%0d", e.layer, cyc, a,
                         e.val[AW-1:0]);
            end
        end
        while (col_q.size() > 0 && col_q[0].cyc <= cyc) begin
            e = col_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL col_missed cyc=%0d due=%0d", cyc, e.cyc);
            end else if (collision !== e.val[N*N-1:0]) begin
                failures++;
                $display("FAIL collision cyc=%0d got=%04h exp=%04h", cyc, collision,
                         e.val[N*N-1:0]);
            end
        end
    end

    function automatic logic [23:0] bg(input int x);
        return {8'h3F, 8'h00, 8'h7F - 8'(x >> 3)};
    endfunction

    task automatic set_layer(input int l, input int x, input int y, input int w, input int h,
                             input logic [23:0] c);
        spr_x[l*CW +: CW]     = CW'(x);
        spr_y[l*CW +: CW]     = CW'(y);
        spr_w[l*CW +: CW]     = CW'(w);
        spr_h[l*CW +: CW]     = CW'(h);
        color_tb[l*COL +: COL] = c;
    endtask

    task automatic exp_addr(input int l, input int a);
        addr_q.push_back('{cyc + 1, l, 24'(a)});
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] e);
        DrawX = CW'(x);
        DrawY = CW'(y);
        pix_q.push_back('{cyc + 3, 0, e});
        @(negedge Clk);
    endtask

    // Off-sprite coordinate, output not checked.
    task automatic idle(input int n);
        DrawX = CW'(600);
        DrawY = CW'(400);
        repeat (n) @(negedge Clk);
    endtask

    task automatic frame(input logic [15:0] e);
        frame_start = 1'b1;
        col_q.push_back('{cyc + 1, 0, {8'h00, e}});
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    initial begin
        Reset       = 1'b1;
        DrawX       = '0;
        DrawY       = '0;
        frame_start = 1'b0;
        layer_en    = '0;
        spr_x       = '0;
        spr_y       = '0;
        spr_w       = '0;
        spr_h       = '0;
        color_tb    = '0;
        for (int l = 0; l < N; l++) set_layer(l, 900, 900, 1, 1, 24'h000000);
        repeat (2) @(negedge Clk);

        // Reset state.
        pix_q.push_back('{cyc + 1, 0, 24'h000000});
        col_q.push_back('{cyc + 1, 0, 24'h000000});
        for (int l = 0; l < N; l++) exp_addr(l, 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Background gradient sweep, first pixel MEM_LAT+2 after reset release.
        for (int x = 0; x < 640; x++) pix(x, 0, bg(x));

        // Box edges and addresses for layer 0 at (100,100) 40x60.
        set_layer(0, 100, 100, 40, 60, 24'h112233);
        layer_en = 4'b0001;
        exp_addr(0, 0);    pix(80, 70, 24'h112233);
        exp_addr(0, 2399); pix(119, 129, 24'h112233);
        exp_addr(0, 0);    pix(120, 129, 24'h3F0070);
        exp_addr(0, 0);    pix(79, 70, 24'h3F0076);
        exp_addr(0, 0);    pix(80, 69, 24'h3F0075);
        exp_addr(0, 0);    pix(80, 130, 24'h3F0075);

        // Priority and transparency with layer 1 at (110,110) 40x60.
        set_layer(1, 110, 110, 40, 60, 24'h445566);
        layer_en = 4'b0011;
        idle(3);
        frame(16'h0000);
        exp_addr(0, 1220);
        exp_addr(1, 810);
        pix(100, 100, 24'h112233);
        color_tb[0 +: COL] = 24'h800080;
        pix(100, 100, 24'h445566);
        idle(3);
        color_tb[0 +: COL] = 24'h112233;

        // Collision capture, then an empty frame.
        frame(16'h0002);
        pix(85, 75, 24'h112233);
        idle(3);
        frame(16'h0000);
        // Hit landing in the frame_start cycle closes with the old frame.
        pix(100, 100, 24'h112233);
        idle(1);
        frame(16'h0002);
        idle(3);
        frame(16'h0000);

        // Partly off-screen sprite: box X -15..24, Y 290..309, no wrap.
        set_layer(0, 100, 100, 40, 60, 24'h112233);
        set_layer(2, 5, 300, 40, 20, 24'hAABBCC);
        layer_en = 4'b0100;
        exp_addr(2, 415); pix(0, 300, 24'hAABBCC);
        exp_addr(2, 439); pix(24, 300, 24'hAABBCC);
        exp_addr(2, 0);   pix(25, 300, 24'h3F007C);
        exp_addr(2, 0);   pix(1000, 300, 24'h3F0002);
        exp_addr(2, 0);   pix(1010, 300, 24'h3F0001);
        // Disabled layer 2 under enabled layer 3 at the same place.
        set_layer(3, 5, 300, 40, 20, 24'h010203);
        layer_en = 4'b1000;
        exp_addr(2, 0); exp_addr(3, 415); pix(0, 300, 24'h010203);
        layer_en = 4'b0000;
        pix(0, 300, 24'h3F007F);
        idle(3);
        frame(16'h0000);

        // Mid-line reset with acc and collision both set.
        layer_en = 4'b0011;
        pix(100, 100, 24'h112233);
        idle(3);
        frame(16'h0002);
        pix(100, 100, 24'h112233);
        idle(3);
        DrawX = CW'(100);
        DrawY = CW'(100);
        Reset = 1'b1;
        pix_q.push_back('{cyc + 1, 0, 24'h000000});
        col_q.push_back('{cyc + 1, 0, 24'h000000});
        exp_addr(0, 0);
        @(negedge Clk);
        pix_q.push_back('{cyc + 1, 0, 24'h000000});
        exp_addr(1, 0);
        @(negedge Clk);
        Reset = 1'b0;
        pix(85, 75, 24'h112233);
        idle(3);
        frame(16'h0000);

        idle(5);
        checks++;
        if (pix_q.size() + addr_q.size() + col_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0",
                     pix_q.size() + addr_q.size() + col_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout cyc=%0d limit=20000", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
